run_checker: RTL and testbench

Hardware sequencer and result checker placed around the `singlecycle` processor. On `start` it holds the processor in reset and drives its start PC, then releases it. It watches the processor's `currentpc` and `MemtoRegOut` and scores each value against a loaded table of (PC threshold, expected value) checkpoints. A watchdog aborts runs that never reach the final checkpoint. It replaces the bench-side pass/fail loop with synthesizable logic, for FPGA self-test.

---
 rtl/run_checker_pkg.sv | 25 ++
 rtl/run_checker_if.sv | 32 +++
 rtl/run_checker_checkpoint_table.sv | 60 ++++++
 rtl/run_checker.sv | 141 ++++++++++++++
 tb/tb_run_checker.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/run_checker_pkg.sv
// Shared types and widths for the run_checker sequencer/scorer and its
// checkpoint table.
package run_checker_pkg;

  localparam int PC_W   = 64;
  localparam int DATA_W = 64;
  localparam int WD_W   = 16;
  localparam int CNT_W  = 8;
  localparam int IDX_W  = 4;
  localparam int MASK_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_RUN,
    ST_DONE,
    ST_TIMEOUT
  } state_e;

  // Saturating increment for the pass counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/run_checker_if.sv
// Host/processor-facing signal bundle of run_checker. The slave side is the
// checker; the master side is whatever drives start/config and models the CPU.
interface run_checker_if;
  import run_checker_pkg::*;

  logic              start;
  logic [PC_W-1:0]   start_pc;
  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_idx;
  logic [PC_W-1:0]   cfg_pc;
  logic [DATA_W-1:0] cfg_val;
  logic [PC_W-1:0]   currentpc;
  logic [DATA_W-1:0] MemtoRegOut;
  logic              proc_resetl;
  logic [PC_W-1:0]   proc_startpc;
  logic [CNT_W-1:0]  passed;
  logic [MASK_W-1:0] fail_mask;
  logic              done;
  logic              all_passed;
  logic              timeout;

  modport master (
    output start, start_pc, cfg_we, cfg_idx, cfg_pc, cfg_val, currentpc, MemtoRegOut,
    input  proc_resetl, proc_startpc, passed, fail_mask, done, all_passed, timeout
  );

  modport slave (
    input  start, start_pc, cfg_we, cfg_idx, cfg_pc, cfg_val, currentpc, MemtoRegOut,
    output proc_resetl, proc_startpc, passed, fail_mask, done, all_passed, timeout
  );

endinterface

// File: rtl/run_checker_checkpoint_table.sv
// Checkpoint register file: one write port, one combinational read port.
// Out-of-range write indices match no entry and are dropped.
module checkpoint_table
  import run_checker_pkg::*;
#(
  parameter int NUM_CHECKS = 2
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [PC_W-1:0]   wr_pc,
  input  logic [DATA_W-1:0] wr_val,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [PC_W-1:0]   rd_pc,
  output logic [DATA_W-1:0] rd_val
);

  logic [NUM_CHECKS*PC_W-1:0]   pc_flat;
  logic [NUM_CHECKS*DATA_W-1:0] val_flat;

  for (genvar gi = 0; gi < NUM_CHECKS; gi++) begin : g_entry
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] val_q, val_d;

    always_comb begin
      pc_d  = pc_q;
      val_d = val_q;
      if (wr_en && (wr_idx == IDX_W'(gi))) begin
        pc_d  = wr_pc;
        val_d = wr_val;
      end
    end

    always_ff @(posedge CLK) begin
      if (reset) begin
        pc_q  <= '0;
        val_q <= '0;
      end else begin
        pc_q  <= pc_d;
        val_q <= val_d;
      end
    end

    assign pc_flat[gi*PC_W +: PC_W]       = pc_q;
    assign val_flat[gi*DATA_W +: DATA_W]  = val_q;
  end

  always_comb begin
    rd_pc  = '0;
    rd_val = '0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_pc  = pc_flat[i*PC_W +: PC_W];
        rd_val = val_flat[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/run_checker.sv
// Holds the processor in reset for a fixed window after start, then scores its
// PC/result stream against the checkpoint table under a watchdog.
module run_checker
  import run_checker_pkg::*;
#(
  parameter int NUM_CHECKS     = 2,
  parameter int WATCHDOG_LIMIT = 255
) (
  input  logic         CLK,
  input  logic         reset,
  run_checker_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHECKS - 1);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(WATCHDOG_LIMIT);
  localparam logic [CNT_W-1:0] ALL_CNT  = CNT_W'(NUM_CHECKS);

  state_e            state_q, state_d;
  logic              hold_cnt_q, hold_cnt_d;
  logic [IDX_W-1:0]  k_q, k_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [CNT_W-1:0]  passed_q, passed_d;
  logic [MASK_W-1:0] fail_mask_q, fail_mask_d;
  logic [PC_W-1:0]   proc_startpc_q, proc_startpc_d;
  logic              proc_resetl_q, proc_resetl_d;
  logic              done_q, done_d;
  logic              all_passed_q, all_passed_d;
  logic              timeout_q, timeout_d;

  logic [PC_W-1:0]   chk_pc;
  logic [DATA_W-1:0] chk_val;
  logic              cfg_ok;
  logic              last_entry;
  logic              wd_expire;

  // The table is only writable while idle so a run always scores against a
  // stable set of checkpoints.
  assign cfg_ok = bus.cfg_we && (state_q == ST_IDLE);

  checkpoint_table #(
    .NUM_CHECKS(NUM_CHECKS)
  ) u_table (
    .CLK    (CLK),
    .reset  (reset),
    .wr_en  (cfg_ok),
    .wr_idx (bus.cfg_idx),
    .wr_pc  (bus.cfg_pc),
    .wr_val (bus.cfg_val),
    .rd_idx (k_q),
    .rd_pc  (chk_pc),
    .rd_val (chk_val)
  );

  always_comb begin
    state_d        = state_q;
    hold_cnt_d     = hold_cnt_q;
    k_d            = k_q;
    wd_d           = wd_q;
    passed_d       = passed_q;
    fail_mask_d    = fail_mask_q;
    proc_startpc_d = proc_startpc_q;
    last_entry     = 1'b0;
    wd_expire      = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_TIMEOUT: begin
        if (bus.start) begin
          state_d        = ST_HOLD;
          hold_cnt_d     = 1'b0;
          k_d            = '0;
          wd_d           = '0;
          passed_d       = '0;
          fail_mask_d    = '0;
          proc_startpc_d = bus.start_pc;
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q) state_d = ST_RUN;
        else            hold_cnt_d = 1'b1;
      end
      ST_RUN: begin
        wd_d      = wd_q + 1'b1;
        wd_expire = (wd_d == WD_LIMIT);
        if (bus.currentpc >= chk_pc) begin
          if (bus.MemtoRegOut == chk_val) passed_d = sat_inc(passed_q);
          else                            fail_mask_d[k_q] = 1'b1;
          k_d        = k_q + 1'b1;
          last_entry = (k_q == LAST_IDX);
        end
        // A final evaluation beats a simultaneous watchdog expiry.
        if (last_entry)     state_d = ST_DONE;
        else if (wd_expire) state_d = ST_TIMEOUT;
      end
      default: state_d = ST_IDLE;
    endcase

    done_d       = (state_d == ST_DONE);
    all_passed_d = done_d && (passed_d == ALL_CNT);
    timeout_d    = (state_d == ST_TIMEOUT);
    // Release lags RUN entry by one cycle, giving three edges after start.
    proc_resetl_d = (state_d == ST_DONE) ||
                    ((state_d == ST_RUN) && (state_q == ST_RUN));
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      hold_cnt_q     <= 1'b0;
      k_q            <= '0;
      wd_q           <= '0;
      passed_q       <= '0;
      fail_mask_q    <= '0;
      proc_startpc_q <= '0;
      proc_resetl_q  <= 1'b0;
      done_q         <= 1'b0;
      all_passed_q   <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      k_q            <= k_d;
      wd_q           <= wd_d;
      passed_q       <= passed_d;
      fail_mask_q    <= fail_mask_d;
      proc_startpc_q <= proc_startpc_d;
      proc_resetl_q  <= proc_resetl_d;
      done_q         <= done_d;
      all_passed_q   <= all_passed_d;
      timeout_q      <= timeout_d;
    end
  end

  assign bus.proc_resetl  = proc_resetl_q;
  assign bus.proc_startpc = proc_startpc_q;
  assign bus.passed       = passed_q;
  assign bus.fail_mask    = fail_mask_q;
  assign bus.done         = done_q;
  assign bus.all_passed   = all_passed_q;
  assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_run_checker.sv
// Self-checking bench for run_checker: directed scenarios plus randomized
// tables and PC/result traces scored by a behavioural model.
module tb_run_checker;

  localparam int N   = 2;
  localparam int LIM = 255;
  localparam logic [63:0] BIG = 64'h1234_5678_9abc_def0;

  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  run_checker_if bus ();

  run_checker #(
    .NUM_CHECKS     (N),
    .WATCHDOG_LIMIT (LIM)
  ) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] m_pc  [N];
  logic [63:0] m_val [N];
  logic [63:0] tr_pc  [$];
  logic [63:0] tr_val [$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_pc[i]  = '0;
      m_val[i] = '0;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_resetl"},  64'(bus.proc_resetl), 64'd0);
    check({tag, "_startpc"}, bus.proc_startpc, 64'd0);
    check({tag, "_passed"},  64'(bus.passed), 64'd0);
    check({tag, "_mask"},    64'(bus.fail_mask), 64'd0);
    check({tag, "_done"},    64'(bus.done), 64'd0);
    check({tag, "_allp"},    64'(bus.all_passed), 64'd0);
    check({tag, "_tmo"},     64'(bus.timeout), 64'd0);
  endtask

  // Table writes are only issued while the DUT is idle; the model keeps
  // in-range entries only.
  task automatic cfg_write(input int idx, input logic [63:0] pc, input logic [63:0] val);
    bus.cfg_we  = 1'b1;
    bus.cfg_idx = 4'(idx);
    bus.cfg_pc  = pc;
    bus.cfg_val = val;
    tick();
    bus.cfg_we  = 1'b0;
    if (idx < N) begin
      m_pc[idx]  = pc;
      m_val[idx] = val;
    end
  endtask

  task automatic build_step(input logic [63:0] bad0);
    tr_pc.delete();
    tr_val.delete();
    for (int c = 0; c < 40; c++) begin
      logic [63:0] p;
      p = 64'(c) * 4;
      tr_pc.push_back(p);
      tr_val.push_back(p == 64'h30 ? bad0 : (p == 64'h5C ? BIG : p));
    end
  endtask

  task automatic build_random(input logic [63:0] spc, input bit stall);
    logic [63:0] p;
    p = spc;
    tr_pc.delete();
    tr_val.delete();
    for (int c = 0; c < 260; c++) begin
      int r;
      r = $urandom_range(0, 7);
      if (c > 0 && !stall) begin
        if (r >= 2 && r < 6) p = p + 64'd4;
        else if (r >= 6)     p = p + 64'($urandom_range(0, 32)) * 4;
      end
      tr_pc.push_back(p);
      if ($urandom_range(0, 3) == 0) tr_val.push_back({$urandom, $urandom});
      else tr_val.push_back(p >= m_pc[N-1] ? m_val[N-1] : m_val[0]);
    end
  endtask

  // One full run: start, hold window, then RUN samples scored by the model
  // until it predicts done or timeout, then a short stability check.
  task automatic do_run(input string name, input logic [63:0] spc,
                        input bit poke_hold, input bit poke_run);
    int          k, wd, npass, sz;
    logic [15:0] mask;
    bit          dn, to, fin;
    logic [63:0] p, v;
    k = 0; wd = 0; npass = 0; mask = '0; dn = 0; to = 0; fin = 0;
    sz = tr_pc.size();

    bus.start    = 1'b1;
    bus.start_pc = spc;
    tick();
    bus.start = 1'b0;
    check({name, "_e0_passed"},  64'(bus.passed), 64'd0);
    check({name, "_e0_mask"},    64'(bus.fail_mask), 64'd0);
    check({name, "_e0_done"},    64'(bus.done), 64'd0);
    check({name, "_e0_tmo"},     64'(bus.timeout), 64'd0);
    check({name, "_e0_resetl"},  64'(bus.proc_resetl), 64'd0);
    check({name, "_e0_startpc"}, bus.proc_startpc, spc);

    if (poke_hold) begin
      bus.start    = 1'b1;
      bus.start_pc = ~spc;
    end
    tick();
    bus.start = 1'b0;
    check({name, "_e1_resetl"},  64'(bus.proc_resetl), 64'd0);
    check({name, "_e1_startpc"}, bus.proc_startpc, spc);
    tick();
    check({name, "_e2_resetl"}, 64'(bus.proc_resetl), 64'd0);

    for (int c = 0; c < 400 && !fin; c++) begin
      p = tr_pc[c < sz ? c : sz - 1];
      v = tr_val[c < sz ? c : sz - 1];
      bus.currentpc   = p;
      bus.MemtoRegOut = v;
      if (poke_run && c == 0) begin
        bus.cfg_we   = 1'b1;
        bus.cfg_idx  = 4'(N - 1);
        bus.cfg_pc   = '1;
        bus.cfg_val  = '0;
        bus.start    = 1'b1;
        bus.start_pc = ~spc;
      end
      tick();
      bus.cfg_we = 1'b0;
      bus.start  = 1'b0;

      wd++;
      if (p >= m_pc[k]) begin
        if (v == m_val[k]) npass++;
        else mask[k] = 1'b1;
        k++;
        if (k == N) begin dn = 1; fin = 1; end
      end
      if (!dn && wd == LIM) begin to = 1; fin = 1; end

      check({name, "_passed"}, 64'(bus.passed), 64'(npass));
      check({name, "_mask"},   64'(bus.fail_mask), 64'(mask));
      check({name, "_done"},   64'(bus.done), 64'(dn));
      check({name, "_tmo"},    64'(bus.timeout), 64'(to));
      check({name, "_allp"},   64'(bus.all_passed), 64'(dn && npass == N));
      check({name, "_resetl"}, 64'(bus.proc_resetl), 64'(!to));
    end

    for (int j = 0; j < 2; j++) begin
      tick();
      check({name, "_hold_passed"}, 64'(bus.passed), 64'(npass));
      check({name, "_hold_done"},   64'(bus.done), 64'(dn));
      check({name, "_hold_tmo"},    64'(bus.timeout), 64'(to));
      check({name, "_hold_resetl"}, 64'(bus.proc_resetl), 64'(dn));
    end
    $display("run %s: passed=%0d mask=0x%0h done=%0b timeout=%0b cycles=%0d",
             name, npass, mask, dn, to, wd);
  endtask

  task automatic load_plan_table();
    cfg_write(0, 64'h30, 64'hF);
    cfg_write(1, 64'h5C, BIG);
  endtask

  initial begin
    bus.start = 0; bus.start_pc = '0; bus.cfg_we = 0; bus.cfg_idx = '0;
    bus.cfg_pc = '0; bus.cfg_val = '0; bus.currentpc = '0; bus.MemtoRegOut = '0;
    reset = 1'b1;
    tick();
    do_reset();
    check_reset_state("rst");

    // Both pass, then a repeat start from DONE with pokes during HOLD/RUN.
    load_plan_table();
    cfg_write(5, 64'h0, 64'hDEAD);
    cfg_write(15, 64'h0, 64'hBEEF);
    build_step(64'hF);
    do_run("both_pass", 64'h0, 0, 0);
    do_run("repeat_pokes", 64'h40, 1, 1);

    // One mismatch at the first checkpoint.
    build_step(64'hE);
    do_run("one_mismatch", 64'h0, 0, 0);

    // Watchdog expiry with the PC stuck below every threshold.
    tr_pc.delete(); tr_val.delete();
    tr_pc.push_back(64'h10); tr_val.push_back(64'h0);
    do_run("watchdog", 64'h10, 0, 0);

    // PC jump across both thresholds.
    tr_pc.delete(); tr_val.delete();
    tr_pc.push_back(64'h00); tr_val.push_back(64'h0);
    tr_pc.push_back(64'h60); tr_val.push_back(64'hF);
    tr_pc.push_back(64'h60); tr_val.push_back(BIG);
    do_run("jump", 64'h0, 0, 0);

    // Reset mid-RUN after one checkpoint has been scored.
    bus.start = 1'b1; bus.start_pc = 64'h8;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    bus.currentpc = 64'h30; bus.MemtoRegOut = 64'hF;
    tick();
    check("midrun_passed", 64'(bus.passed), 64'd1);
    do_reset();
    check_reset_state("midrun_rst");
    // An all-zero table scores at the very first samples with zero results.
    tr_pc.delete(); tr_val.delete();
    tr_pc.push_back(64'h0); tr_val.push_back(64'h0);
    do_run("zero_table", 64'h0, 0, 0);
    do_reset();
    load_plan_table();
    build_step(64'hF);
    do_run("reloaded", 64'h0, 0, 0);

    // Randomized tables and traces.
    for (int t = 0; t < 16; t++) begin
      logic [63:0] spc;
      do_reset();
      cfg_write(0, 64'($urandom_range(0, 64)) * 4, {$urandom, $urandom});
      cfg_write(1, m_pc[0] + 64'($urandom_range(0, 64)) * 4, {$urandom, $urandom});
      cfg_write($urandom_range(N, 15), {$urandom, $urandom}, {$urandom, $urandom});
      spc = 64'($urandom_range(0, 16)) * 4;
      build_random(spc, $urandom_range(0, 7) == 0);
      do_run($sformatf("rand%0d", t), spc, 1'($urandom_range(0, 1)), 0);
      build_random(spc, 0);
      do_run($sformatf("rand%0d_rerun", t), spc, 0, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
